rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/rst_seq_wdt.sv | 39 +++
 rtl/rst_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset cause codes and a counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_CLKON   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SOFT = 2'd1,
    CAUSE_WDT  = 2'd2
  } rst_cause_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rst_seq_wdt.sv
// Watchdog for the reset sequencer (built only with RST_SEQ_WDT_EN): counts down while the
// system runs, reloads on kick or whenever not running; expire_o is combinational, no backpressure.
module rst_seq_wdt
  import rst_seq_pkg::*;
#(
  parameter int WDT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int W = cnt_width(WDT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Holding the reload value outside RUN gives a fresh window on every RUN entry.
  always_comb begin
    cnt_d = cnt_q;
    if (kick_i || !run_i) begin
      cnt_d = W'(WDT_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= W'(WDT_CYC - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && !kick_i && (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset/clock sequencer: hold, clock-on, staggered per-domain release, then RUN; POR latency
// HOLD_CYC+2+(NUM_DOM-1)*STAGGER_CYC+1. Soft requests wait in RUN only. Watchdog under RST_SEQ_WDT_EN.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM     = 4,
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 8
`ifdef RST_SEQ_WDT_EN
  , parameter int WDT_CYC   = 1024
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] soft_rst_req_i,
  output logic [NUM_REQ-1:0] soft_rst_ack_o,
  output logic [NUM_DOM-1:0] dom_clk_en_o,
  output logic [NUM_DOM-1:0] dom_rst_o,
  output logic               seq_done_o,
  output logic [1:0]         rst_cause_o
`ifdef RST_SEQ_WDT_EN
  , input  logic             wdt_kick_i
`endif
);

  localparam int CNT_MAX = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC - 1 : STAGGER_CYC - 1;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int IDX_W   = cnt_width(NUM_DOM - 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOM - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  rst_cause_e        cause_q, cause_d;
  logic [NUM_REQ-1:0] req_lowest;
  logic              wdt_expire;

`ifdef RST_SEQ_WDT_EN
  rst_seq_wdt #(
    .WDT_CYC (WDT_CYC)
  ) u_wdt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (state_q == ST_RUN),
    .kick_i   (wdt_kick_i),
    .expire_o (wdt_expire)
  );
`else
  assign wdt_expire = 1'b0;
`endif

  assign req_lowest = soft_rst_req_i & (~soft_rst_req_i + NUM_REQ'(1));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    cause_d        = cause_q;
    soft_rst_ack_o = '0;
    dom_rst_o      = '1;
    dom_clk_en_o   = '0;
    seq_done_o     = 1'b0;

    unique case (state_q)
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = ST_CLKON;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_CLKON: begin
        dom_clk_en_o = '1;
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          idx_d   = '0;
          cnt_d   = STAGGER_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        dom_clk_en_o = '1;
        // Domains at or below the index are already out of reset.
        for (int i = 0; i < NUM_DOM; i++) begin
          dom_rst_o[i] = (IDX_W'(i) > idx_q);
        end
        if (idx_q == IDX_LAST) begin
          state_d = ST_RUN;
        end else if (cnt_q == '0) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = STAGGER_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RUN: begin
        dom_clk_en_o = '1;
        dom_rst_o    = '0;
        seq_done_o   = 1'b1;
        if (wdt_expire) begin
          state_d = ST_ASSERT;
          cnt_d   = HOLD_LOAD;
          idx_d   = '0;
          cause_d = CAUSE_WDT;
        end else if (soft_rst_req_i != '0) begin
          soft_rst_ack_o = rst_i ? '0 : req_lowest;
          state_d        = ST_ASSERT;
          cnt_d          = HOLD_LOAD;
          idx_d          = '0;
          cause_d        = CAUSE_SOFT;
        end
      end

      default: state_d = ST_ASSERT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= HOLD_LOAD;
      idx_q   <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cause_q <= cause_d;
    end
  end

  assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: timeline model plus literal waypoints; exercises the watchdog when RST_SEQ_WDT_EN is set.
module tb_rst_seq_ctrl;

  localparam int N        = 4;
  localparam int R        = 2;
  localparam int H        = 16;
  localparam int S        = 8;
  localparam int DONE_REL = H + 2 + (N - 1) * S + 1;
`ifdef RST_SEQ_WDT_EN
  localparam int WDT      = 100;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [R-1:0] req = '0;
  logic [R-1:0] ack;
  logic [N-1:0] clk_en;
  logic [N-1:0] dom_rst;
  logic         done;
  logic [1:0]   cause;
`ifdef RST_SEQ_WDT_EN
  logic         kick = 1'b0;
`endif

  rst_seq_ctrl #(
    .NUM_DOM     (N),
    .NUM_REQ     (R),
    .HOLD_CYC    (H),
    .STAGGER_CYC (S)
`ifdef RST_SEQ_WDT_EN
    , .WDT_CYC   (WDT)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .soft_rst_req_i (req),
    .soft_rst_ack_o (ack),
    .dom_clk_en_o   (clk_en),
    .dom_rst_o      (dom_rst),
    .seq_done_o     (done),
    .rst_cause_o    (cause)
`ifdef RST_SEQ_WDT_EN
    , .wdt_kick_i   (kick)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: every output is a function of cycles elapsed since the current sequence began.
  int s0       = 0;
  int mcause   = 0;
  bit started  = 1'b0;
  int deadline = 0;

  always @(negedge clk) begin
    int           rel;
    logic [N-1:0] e_rst;
    logic [N-1:0] e_clk;
    logic         e_done;
    logic [R-1:0] e_ack;
    logic         fire;
    rel = 0; e_rst = '1; e_clk = '0; e_done = 1'b0; e_ack = '0; fire = 1'b0;
    if (started) begin
      rel    = cyc - s0;
      e_clk  = (rel >= H) ? '1 : '0;
      for (int i = 0; i < N; i++) e_rst[i] = (rel < H + 2 + i * S);
      e_done = (rel >= DONE_REL);
`ifdef RST_SEQ_WDT_EN
      fire = e_done && !rst && !kick && (cyc == deadline);
`endif
      if (e_done && !rst && !fire) begin
        for (int i = R - 1; i >= 0; i--) begin
          if (req[i]) begin
            e_ack    = '0;
            e_ack[i] = 1'b1;
          end
        end
      end
      chk("model clk_en", 32'(clk_en), 32'(e_clk));
      chk("model dom_rst", 32'(dom_rst), 32'(e_rst));
      chk("model seq_done", 32'(done), 32'(e_done));
      chk("model ack", 32'(ack), 32'(e_ack));
      chk("model cause", 32'(cause), 32'(mcause));
    end
    if (rst) begin
      s0      = cyc + 1;
      mcause  = 0;
      started = 1'b1;
`ifdef RST_SEQ_WDT_EN
      deadline = s0 + DONE_REL + WDT - 1;
`endif
    end else if (fire || e_ack != '0) begin
      s0     = cyc + 1;
      mcause = fire ? 2 : 1;
`ifdef RST_SEQ_WDT_EN
      deadline = s0 + DONE_REL + WDT - 1;
`endif
    end
`ifdef RST_SEQ_WDT_EN
    else if (e_done && kick) begin
      deadline = cyc + WDT;
    end
`endif
  end

  task automatic drive_at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic look_at(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0;
    drive_at(3);
    rst = 1'b0;
    t0  = cyc;

    look_at(t0 + 1);  chk("por cause", 32'(cause), 0); chk("por ack", 32'(ack), 0);
    look_at(t0 + 15); chk("hold clk_en", 32'(clk_en), 0); chk("hold dom_rst", 32'(dom_rst), 32'hF);
    look_at(t0 + 16); chk("clkon clk_en", 32'(clk_en), 32'hF); chk("clkon dom_rst", 32'(dom_rst), 32'hF);
    look_at(t0 + 17); chk("clkon2 dom_rst", 32'(dom_rst), 32'hF);
    look_at(t0 + 18); chk("rel0 dom_rst", 32'(dom_rst), 32'hE);
    look_at(t0 + 25); chk("rel0 hold", 32'(dom_rst), 32'hE);
    look_at(t0 + 26); chk("rel1 dom_rst", 32'(dom_rst), 32'hC);

    drive_at(t0 + 30); req = 2'b01;
    look_at(t0 + 34); chk("rel2 dom_rst", 32'(dom_rst), 32'h8); chk("no ack in release", 32'(ack), 0);
    look_at(t0 + 41); chk("pre rel3 dom_rst", 32'(dom_rst), 32'h8); chk("pre run done", 32'(done), 0);
    look_at(t0 + 42); chk("rel3 dom_rst", 32'(dom_rst), 0); chk("rel3 done", 32'(done), 0);
    chk("rel3 ack", 32'(ack), 0);
    look_at(t0 + 43); chk("run done", 32'(done), 1); chk("first run ack", 32'(ack), 32'h1);

    drive_at(t0 + 44); req = 2'b00;
    look_at(t0 + 44); chk("soft cause", 32'(cause), 1); chk("soft restart dom_rst", 32'(dom_rst), 32'hF);
    chk("soft restart clk_en", 32'(clk_en), 0);

    drive_at(t0 + 95); req = 2'b11;
    look_at(t0 + 95); chk("arb ack", 32'(ack), 32'h1); chk("arb done", 32'(done), 1);
    drive_at(t0 + 96); req = 2'b10;
    look_at(t0 + 96); chk("arb post ack", 32'(ack), 0); chk("arb cause", 32'(cause), 1);
    chk("arb restart done", 32'(done), 0);
    look_at(t0 + 138); chk("held req waits", 32'(ack), 0);
    look_at(t0 + 139); chk("held req ack", 32'(ack), 32'h2); chk("held req done", 32'(done), 1);
    drive_at(t0 + 140); req = 2'b00;

    drive_at(t0 + 170); rst = 1'b1;
    look_at(t0 + 170); chk("mid rst dom_rst", 32'(dom_rst), 32'hC);
    drive_at(t0 + 171); rst = 1'b0;
    look_at(t0 + 171); chk("rst dom_rst", 32'(dom_rst), 32'hF); chk("rst clk_en", 32'(clk_en), 0);
    chk("rst done", 32'(done), 0); chk("rst cause", 32'(cause), 0);
    look_at(t0 + 213); chk("restart pre done", 32'(done), 0);
    look_at(t0 + 214); chk("restart done", 32'(done), 1);

    drive_at(t0 + 220); rst = 1'b1; req = 2'b01;
    look_at(t0 + 220); chk("rst beats req ack", 32'(ack), 0);
    drive_at(t0 + 221); rst = 1'b0; req = 2'b00;
    look_at(t0 + 221); chk("rst beats req cause", 32'(cause), 0);
    look_at(t0 + 264); chk("third run done", 32'(done), 1);

`ifdef RST_SEQ_WDT_EN
    for (int k = 0; k < 5; k++) begin
      drive_at(t0 + 304 + k * 50); kick = 1'b1;
      drive_at(t0 + 305 + k * 50); kick = 1'b0;
    end
    look_at(t0 + 600); chk("kicked still run", 32'(done), 1);
    drive_at(t0 + 604); req = 2'b01;
    look_at(t0 + 604); chk("wdt beats req ack", 32'(ack), 0); chk("wdt last run", 32'(done), 1);
    drive_at(t0 + 605); req = 2'b00;
    look_at(t0 + 605); chk("wdt done", 32'(done), 0); chk("wdt cause", 32'(cause), 2);
    drive_at(t0 + 620);
`else
    drive_at(t0 + 300);
    look_at(t0 + 300); chk("idle run", 32'(done), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
